// File: rtl/demux14_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : demux14_scheduler_if
// Brief    : Request / data handshake and demux-output bundle for the
//            four-way round-robin demux scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface demux14_scheduler_if;
  logic [3:0] iReq;      // destination requests, bit k = destination k
  logic       iValid;    // source data valid
  logic       iC;        // source data bit
  logic       oReady;    // scheduler accepts iC this cycle
  logic       oS1;       // demux select, MSB
  logic       oS0;       // demux select, LSB
  logic [3:0] oGnt;      // one-hot grant
  logic       oZ0;
  logic       oZ1;
  logic       oZ2;
  logic       oZ3;
  logic       oStrb;     // one-cycle strobe after each accepted bit
  logic       oTimeout;  // one-cycle pulse on forced release

  // Source / requester side
  modport master (
    output iReq, iValid, iC,
    input  oReady, oS1, oS0, oGnt, oZ0, oZ1, oZ2, oZ3, oStrb, oTimeout
  );

  // Scheduler side
  modport slave (
    input  iReq, iValid, iC,
    output oReady, oS1, oS0, oGnt, oZ0, oZ1, oZ2, oZ3, oStrb, oTimeout
  );
endinterface
`default_nettype wire

// File: rtl/demux14_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : demux14_scheduler
// Brief    : Round-robin scheduler sharing one serial source among four
//            destinations through a 1-to-4 demux. Grants one requester at a
//            time, moves bits with a valid/ready handshake and releases the
//            grant after BURST_LEN beats or when the requester withdraws.
//            Optional feature macro: DEMUX14_SCHED_TIMEOUT_EN enables a
//            stall counter that force-releases a grant after TIMEOUT
//            stalled cycles and pulses oTimeout.
// Revision : 1.0  initial release
// ============================================================================
module demux14_scheduler #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                 iClk,
  input  logic                 iRst,
  demux14_scheduler_if.slave   io_bus
);

  localparam int              c_BW   = $clog2(BURST_LEN + 1);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(BURST_LEN - 1);
  localparam logic [c_BW-1:0] c_ONE  = c_BW'(1);

  // Reject parameter values the scheduler cannot honour.
  if (BURST_LEN < 1 || TIMEOUT < 1) begin : g_param_check
    $error("demux14_scheduler: BURST_LEN and TIMEOUT must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr,   w_ptr_nxt;
  logic [1:0]      r_sel,   w_sel_nxt;
  logic [3:0]      r_gnt,   w_gnt_nxt;
  logic [3:0]      r_z,     w_z_nxt;
  logic            r_strb,  w_strb_nxt;
  logic [c_BW-1:0] r_beat,  w_beat_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            w_ready;
  logic            w_xfer;
  logic            w_stall_hit;

  // First set request bit scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] v_idx;
    logic [1:0] v_win;
    logic       v_found;
    v_win   = ptr;
    v_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v_idx = ptr + 2'(i);
      if (!v_found && req[v_idx]) begin
        v_win   = v_idx;
        v_found = 1'b1;
      end
    end
    return v_win;
  endfunction

  // Ready only while granted and the granted requester still asks.
  assign w_ready = (r_state == ST_XFER) && io_bus.iReq[r_sel];
  assign w_xfer  = w_ready && io_bus.iValid;

`ifdef DEMUX14_SCHED_TIMEOUT_EN
  localparam int              c_SW    = $clog2(TIMEOUT + 1);
  localparam logic [c_SW-1:0] c_TLAST = c_SW'(TIMEOUT - 1);

  logic [c_SW-1:0] r_stall;

  // Count stalled XFER cycles; cleared in IDLE so each grant starts at zero.
  always_ff @(posedge iClk) begin
    if (iRst || r_state == ST_IDLE || w_xfer) begin
      r_stall <= '0;
    end else if (w_ready) begin
      r_stall <= r_stall + c_SW'(1);
    end
  end

  // The stall that would bring the count to TIMEOUT forces release.
  assign w_stall_hit = w_ready && !w_xfer && (r_stall == c_TLAST);
`else
  assign w_stall_hit = 1'b0;
`endif

  // Next-state and next-output computation for the IDLE/XFER machine.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = r_gnt;
    w_z_nxt       = 4'b0000;
    w_strb_nxt    = 1'b0;
    w_beat_nxt    = r_beat;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|io_bus.iReq) begin
          w_sel_nxt   = f_rr_pick(io_bus.iReq, r_ptr);
          w_gnt_nxt   = 4'b0001 << w_sel_nxt;
          w_beat_nxt  = '0;
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_xfer) begin
          w_z_nxt[r_sel] = io_bus.iC;
          w_strb_nxt     = 1'b1;
          w_beat_nxt     = r_beat + c_ONE;
        end
        // Burst complete, requester withdrew, or stall limit reached.
        if ((w_xfer && r_beat == c_LAST) || !io_bus.iReq[r_sel] || w_stall_hit) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = 4'b0000;
          w_ptr_nxt     = r_sel + 2'd1;
          w_timeout_nxt = w_stall_hit;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs; reset aborts any burst in progress.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_sel     <= 2'd0;
      r_gnt     <= 4'b0000;
      r_z       <= 4'b0000;
      r_strb    <= 1'b0;
      r_beat    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_z       <= w_z_nxt;
      r_strb    <= w_strb_nxt;
      r_beat    <= w_beat_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign io_bus.oReady   = w_ready;
  assign io_bus.oS1      = r_sel[1];
  assign io_bus.oS0      = r_sel[0];
  assign io_bus.oGnt     = r_gnt;
  assign io_bus.oZ0      = r_z[0];
  assign io_bus.oZ1      = r_z[1];
  assign io_bus.oZ2      = r_z[2];
  assign io_bus.oZ3      = r_z[3];
  assign io_bus.oStrb    = r_strb;
  assign io_bus.oTimeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_demux14_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux14_scheduler
// Brief    : Directed self-checking bench for demux14_scheduler: reset,
//            single requester, round-robin order, withdrawal, stall and
//            reset in the middle of a burst.
// Revision : 1.0  initial release
// ============================================================================
module tb_demux14_scheduler;

  logic iClk = 1'b0;
  logic iRst;

  demux14_scheduler_if bus ();

  demux14_scheduler #(
    .BURST_LEN (4),
    .TIMEOUT   (8)
  ) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .io_bus (bus)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] w_z;
  logic [1:0] w_sel;
  assign w_z   = {bus.oZ3, bus.oZ2, bus.oZ1, bus.oZ0};
  assign w_sel = {bus.oS1, bus.oS0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic t2_bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int   order   [5] = '{0, 1, 2, 3, 0};

  initial begin
    // T1: reset with all requests and valid asserted
    iRst       = 1'b1;
    bus.iReq   = 4'b1111;
    bus.iValid = 1'b1;
    bus.iC     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t1_gnt",     32'(bus.oGnt),     32'h0);
      check("t1_z",       32'(w_z),          32'h0);
      check("t1_sel",     32'(w_sel),        32'h0);
      check("t1_ready",   32'(bus.oReady),   32'h0);
      check("t1_strb",    32'(bus.oStrb),    32'h0);
      check("t1_timeout", 32'(bus.oTimeout), 32'h0);
    end
    iRst     = 1'b0;
    bus.iReq = 4'b0000;
    tick();

    // T2: single requester on destination 2, bits 1,0,1,1
    bus.iReq   = 4'b0100;
    bus.iValid = 1'b1;
    tick();
    check("t2_gnt",   32'(bus.oGnt),   32'h4);
    check("t2_sel",   32'(w_sel),      32'h2);
    check("t2_ready", 32'(bus.oReady), 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus.iC = t2_bits[i];
      tick();
      check("t2_strb", 32'(bus.oStrb), 32'h1);
      check("t2_z",    32'(w_z),       t2_bits[i] ? 32'h4 : 32'h0);
    end
    check("t2_release_gnt", 32'(bus.oGnt), 32'h0);
    bus.iReq = 4'b0000;
    tick();
    check("t2_idle_strb", 32'(bus.oStrb), 32'h0);
    check("t2_idle_z",    32'(w_z),       32'h0);

    // T3: round robin with all four requesting, starting from ptr=0
    iRst = 1'b1;
    tick();
    iRst       = 1'b0;
    bus.iReq   = 4'b1111;
    bus.iValid = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t3_gnt",       32'(bus.oGnt), 32'(1 << order[g]));
      check("t3_sel",       32'(w_sel),    32'(order[g]));
      check("t3_gap_strb",  32'(bus.oStrb), 32'h0);
      for (int b = 0; b < 4; b++) begin
        bus.iC = (b % 2 == 1);
        tick();
        check("t3_strb", 32'(bus.oStrb), 32'h1);
        check("t3_z",    32'(w_z),       (b % 2 == 1) ? 32'(1 << order[g]) : 32'h0);
      end
      check("t3_release_gnt", 32'(bus.oGnt), 32'h0);
    end

    // T4: destination 1 withdraws after 2 beats (ptr is 1 here)
    bus.iReq = 4'b0010;
    tick();
    check("t4_gnt", 32'(bus.oGnt), 32'h2);
    bus.iC = 1'b1;
    for (int b = 0; b < 2; b++) begin
      tick();
      check("t4_strb", 32'(bus.oStrb), 32'h1);
    end
    bus.iReq = 4'b1001;
    #1;
    check("t4_ready_drop", 32'(bus.oReady), 32'h0);
    tick();
    check("t4_no_third_strb", 32'(bus.oStrb), 32'h0);
    check("t4_release_gnt",   32'(bus.oGnt),  32'h0);
    tick();
    check("t4_next_gnt", 32'(bus.oGnt), 32'h8);
    check("t4_next_sel", 32'(w_sel),    32'h3);

    // T5: destination 3 granted, source stalls for 10 cycles
    bus.iValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_strb", 32'(bus.oStrb), 32'h0);
`ifdef DEMUX14_SCHED_TIMEOUT_EN
      check("t5_gnt",     32'(bus.oGnt),     (i < 7) ? 32'h8 : ((i == 7) ? 32'h0 : 32'h1));
      check("t5_timeout", 32'(bus.oTimeout), (i == 7) ? 32'h1 : 32'h0);
`else
      check("t5_gnt",     32'(bus.oGnt),     32'h8);
      check("t5_timeout", 32'(bus.oTimeout), 32'h0);
`endif
    end
    bus.iReq = 4'b0000;
    tick();
    check("t5_release_gnt", 32'(bus.oGnt), 32'h0);

    // Move ptr to 2 so the reset test can tell whether ptr was cleared.
    bus.iReq = 4'b0010;
    tick();
    check("pre_t6_gnt", 32'(bus.oGnt), 32'h2);
    bus.iReq = 4'b0000;
    tick();
    check("pre_t6_release", 32'(bus.oGnt), 32'h0);

    // T6: reset on beat 2 of a grant to destination 2
    bus.iReq   = 4'b0100;
    bus.iValid = 1'b1;
    bus.iC     = 1'b1;
    tick();
    check("t6_gnt", 32'(bus.oGnt), 32'h4);
    tick();
    check("t6_beat1_strb", 32'(bus.oStrb), 32'h1);
    iRst = 1'b1;
    tick();
    check("t6_rst_gnt",   32'(bus.oGnt),   32'h0);
    check("t6_rst_z",     32'(w_z),        32'h0);
    check("t6_rst_strb",  32'(bus.oStrb),  32'h0);
    check("t6_rst_sel",   32'(w_sel),      32'h0);
    check("t6_rst_ready", 32'(bus.oReady), 32'h0);
    iRst     = 1'b0;
    bus.iReq = 4'b0110;
    tick();
    check("t6_first_gnt", 32'(bus.oGnt), 32'h2);
    check("t6_first_sel", 32'(w_sel),    32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
